ibex_imem_responder: RTL and testbench

IBEX_IMEM_RESPONDER -- requirements
Module: ibex_imem_responder

---
 rtl/ibex_pkg.sv | 24 ++
 rtl/ibex_imem_array.sv | 35 +++
 rtl/ibex_imem_responder.sv | 115 +++++++++++
 tb/tb_ibex_imem_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// ibex_pkg: shared instruction-bus constants and types for the instruction
// memory responder.
//   BusDataWidth    - width of a fetched instruction word
//   BusAddrWidth    - width of a fetch byte address
//   WordOffsetWidth - byte-offset bits below a word address
//   resp_t          - one slot of the response pipeline {valid, err, data}
package ibex_pkg;

  localparam int unsigned BusDataWidth    = 32;
  localparam int unsigned BusAddrWidth    = 32;
  localparam int unsigned WordOffsetWidth = 2;

  typedef struct packed {
    logic                    valid;
    logic                    err;
    logic [BusDataWidth-1:0] data;
  } resp_t;

  // A fetch address is word aligned when its byte-offset bits are zero.
  function automatic logic is_word_aligned(input logic [WordOffsetWidth-1:0] offset);
    return offset == '0;
  endfunction

endpackage

// File: rtl/ibex_imem_array.sv
// ibex_imem_array: backing store for the instruction memory responder.
// One synchronous write port (used for preloading) and one combinational
// read port (used at grant time). Contents are never reset.
//   clk   - clock
//   we    - write enable
//   waddr - write word index
//   wdata - write data
//   raddr - read word index
//   rdata - read data, combinational from raddr
module ibex_imem_array
  import ibex_pkg::*;
#(
  parameter  int unsigned Words = 1024,
  localparam int unsigned IdxW  = $clog2(Words)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [IdxW-1:0]         waddr,
  input  logic [BusDataWidth-1:0] wdata,
  input  logic [IdxW-1:0]         raddr,
  output logic [BusDataWidth-1:0] rdata
);

  logic [BusDataWidth-1:0] mem [Words];

  // Storage has no reset so that preloaded programs survive a core reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ibex_imem_responder.sv
// ibex_imem_responder: models an instruction memory on the Ibex fetch bus.
// Requests are granted combinationally, looked up at grant time and answered
// in order exactly RespLatency cycles later through a fixed-depth pipeline.
//   clk_i          - clock
//   rst_ni         - asynchronous active-low reset
//   instr_req_i    - fetch request
//   instr_addr_i   - fetch byte address
//   instr_gnt_o    - request accepted this cycle
//   instr_rvalid_o - response valid this cycle
//   instr_rdata_o  - response data (zero unless a good response)
//   instr_err_o    - response is a bus error (qualified by rvalid)
//   stall_i        - withhold grant
//   load_we_i      - backing-store preload write enable (blocks grant)
//   load_addr_i    - preload word index
//   load_wdata_i   - preload data
//   busy_o         - at least one request outstanding
module ibex_imem_responder
  import ibex_pkg::*;
#(
  parameter int unsigned       MemWords       = 1024,
  parameter logic [31:0]       BaseAddr       = 32'h0000_0000,
  parameter int unsigned       RespLatency    = 1,
  parameter int unsigned       MaxOutstanding = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        instr_req_i,
  input  logic [BusAddrWidth-1:0]     instr_addr_i,
  output logic                        instr_gnt_o,
  output logic                        instr_rvalid_o,
  output logic [BusDataWidth-1:0]     instr_rdata_o,
  output logic                        instr_err_o,
  input  logic                        stall_i,
  input  logic                        load_we_i,
  input  logic [$clog2(MemWords)-1:0] load_addr_i,
  input  logic [BusDataWidth-1:0]     load_wdata_i,
  output logic                        busy_o
);

  localparam int unsigned IdxW   = $clog2(MemWords);
  localparam logic [2:0]  MaxCnt = 3'(MaxOutstanding);

  logic [2:0]              outstanding;
  logic [BusAddrWidth-1:0] offset;
  logic                    in_range;
  logic                    req_err;
  logic [BusDataWidth-1:0] rd_data;
  resp_t                   new_resp;
  resp_t                   pipe [RespLatency];
  logic                    resp_valid;

  // Window check: BaseAddr is aligned to the window size, so an address is
  // inside the memory exactly when the offset has no bits above the window.
  assign offset   = instr_addr_i - BaseAddr;
  assign in_range = (offset >> (IdxW + WordOffsetWidth)) == '0;
  assign req_err  = ~is_word_aligned(offset[WordOffsetWidth-1:0]) | ~in_range;

  assign instr_gnt_o = instr_req_i & ~stall_i & ~load_we_i & (outstanding < MaxCnt);

  ibex_imem_array #(
    .Words (MemWords)
  ) u_array (
    .clk   (clk_i),
    .we    (load_we_i),
    .waddr (load_addr_i),
    .wdata (load_wdata_i),
    .raddr (offset[IdxW+WordOffsetWidth-1:WordOffsetWidth]),
    .rdata (rd_data)
  );

  // Data is captured at grant time so later preloads cannot alter it.
  always_comb begin
    new_resp       = '0;
    new_resp.valid = instr_gnt_o;
    new_resp.err   = instr_gnt_o & req_err;
    new_resp.data  = (instr_gnt_o & ~req_err) ? rd_data : '0;
  end

  // Shift chain: stage 0 is loaded in the grant cycle, the last stage drives
  // the outputs, giving exactly RespLatency cycles from grant to rvalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(RespLatency); i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= new_resp;
      for (int i = 1; i < int'(RespLatency); i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign resp_valid     = pipe[RespLatency-1].valid;
  assign instr_rvalid_o = resp_valid;
  assign instr_err_o    = resp_valid & pipe[RespLatency-1].err;
  assign instr_rdata_o  = resp_valid ? pipe[RespLatency-1].data : '0;

  // Grant and response in the same cycle cancel out, which keeps the count
  // bounded by MaxOutstanding and never below zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= '0;
    end else begin
      case ({instr_gnt_o, resp_valid})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign busy_o = outstanding != '0;

endmodule

// File: tb/tb_ibex_imem_responder.sv
// tb_ibex_imem_responder: self-checking bench for ibex_imem_responder.
// Three instances share one stimulus stream (latencies 1, 3 and 2, all with
// two outstanding); a per-cycle reference model predicts every output and
// directed scenarios add hand-computed literal expectations.
module tb_ibex_imem_responder;

  localparam int NInst = 3;
  localparam int MaxC  = 512;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        stall;
  logic        we;
  logic [9:0]  load_addr;
  logic [31:0] load_wdata;

  logic [NInst-1:0] gnt;
  logic [NInst-1:0] rvalid;
  logic [NInst-1:0] err;
  logic [NInst-1:0] busy;
  logic [31:0]      rdata [NInst];

  int n_checks;
  int n_pass;
  int cyc;

  int          lat [NInst] = '{1, 3, 2};
  int          cnt [NInst];
  bit          sched_v [NInst][MaxC];
  bit          sched_e [NInst][MaxC];
  logic [31:0] sched_d [NInst][MaxC];
  logic [31:0] mem_model [1024];

  ibex_imem_responder #(.MemWords(1024), .BaseAddr(32'h0), .RespLatency(1), .MaxOutstanding(2)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[0]), .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]), .instr_err_o(err[0]),
    .stall_i(stall), .load_we_i(we), .load_addr_i(load_addr), .load_wdata_i(load_wdata), .busy_o(busy[0]));

  ibex_imem_responder #(.MemWords(1024), .BaseAddr(32'h0), .RespLatency(3), .MaxOutstanding(2)) u_l3 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[1]), .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]), .instr_err_o(err[1]),
    .stall_i(stall), .load_we_i(we), .load_addr_i(load_addr), .load_wdata_i(load_wdata), .busy_o(busy[1]));

  ibex_imem_responder #(.MemWords(1024), .BaseAddr(32'h0), .RespLatency(2), .MaxOutstanding(2)) u_l2 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[2]), .instr_rvalid_o(rvalid[2]), .instr_rdata_o(rdata[2]), .instr_err_o(err[2]),
    .stall_i(stall), .load_we_i(we), .load_addr_i(load_addr), .load_wdata_i(load_wdata), .busy_o(busy[2]));

  // Free-running clock and a cycle index that advances on every rising edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [31:0] a, input logic s,
                               input logic w, input logic [9:0] la, input logic [31:0] wd);
    @(posedge clk);
    #1;
    req        = r;
    addr       = a;
    stall      = s;
    we         = w;
    load_addr  = la;
    load_wdata = wd;
  endtask

  task automatic waitSample();
    @(negedge clk);
    #1;
  endtask

  // Reference model: responses are scheduled by absolute cycle number at
  // grant time, the outstanding count is grants minus responses, and reset
  // wipes every response not yet delivered.
  always @(negedge clk) begin
    for (int i = 0; i < NInst; i++) begin
      logic        exp_gnt;
      logic        exp_rv;
      logic        e;
      logic [31:0] d;
      if (!rst_n) begin
        cnt[i] = 0;
        for (int k = cyc; k < MaxC; k++) sched_v[i][k] = 1'b0;
        checkOutput($sformatf("rst_rvalid%0d", i), 32'(rvalid[i]), 32'd0);
        checkOutput($sformatf("rst_err%0d", i), 32'(err[i]), 32'd0);
        checkOutput($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
        checkOutput($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
      end else begin
        exp_gnt = req && !stall && !we && (cnt[i] < 2);
        exp_rv  = (cyc < MaxC) ? sched_v[i][cyc] : 1'b0;
        checkOutput($sformatf("gnt%0d", i), 32'(gnt[i]), 32'(exp_gnt));
        checkOutput($sformatf("rvalid%0d", i), 32'(rvalid[i]), 32'(exp_rv));
        checkOutput($sformatf("err%0d", i), 32'(err[i]), exp_rv ? 32'(sched_e[i][cyc]) : 32'd0);
        checkOutput($sformatf("rdata%0d", i), rdata[i], exp_rv ? sched_d[i][cyc] : 32'd0);
        checkOutput($sformatf("busy%0d", i), 32'(busy[i]), 32'(cnt[i] != 0));
        if (exp_gnt && (cyc + lat[i] < MaxC)) begin
          e = (addr[1:0] != 2'b00) || (addr >= 32'h0000_1000);
          d = e ? 32'd0 : mem_model[addr[11:2]];
          sched_v[i][cyc + lat[i]] = 1'b1;
          sched_e[i][cyc + lat[i]] = e;
          sched_d[i][cyc + lat[i]] = d;
        end
        cnt[i] = cnt[i] + int'(exp_gnt) - int'(exp_rv);
      end
    end
    if (we) mem_model[load_addr] = load_wdata;
  end

  // Directed scenarios with literal expectations pinning the model.
  initial begin
    logic [31:0] words [4];
    words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    rst_n = 1'b0; req = 1'b0; addr = 32'h0; stall = 1'b0;
    we = 1'b0; load_addr = 10'd0; load_wdata = 32'h0;

    // Reset state.
    waitSample();
    checkOutput("reset_rvalid", 32'(rvalid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    applyStimulus(0, 32'h0, 0, 0, 10'd0, 32'h0);
    rst_n = 1'b1;

    // Preload words 0..3 and stream four back-to-back reads.
    for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 0, 1, 10'(i), words[i]);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i < 4, 32'(4 * i), 0, 0, 10'd0, 32'h0);
      waitSample();
      checkOutput("b2b_gnt", 32'(gnt[0]), (i < 4) ? 32'd1 : 32'd0);
      checkOutput("b2b_rvalid", 32'(rvalid[0]), (i > 0) ? 32'd1 : 32'd0);
      checkOutput("b2b_rdata", rdata[0], (i > 0) ? words[i-1] : 32'd0);
      checkOutput("b2b_err", 32'(err[0]), 32'd0);
    end
    for (int i = 0; i < 6; i++) applyStimulus(0, 32'h0, 0, 0, 10'd0, 32'h0);

    // Outstanding limit on the latency-3 instance.
    for (int i = 0; i < 5; i++) begin
      logic [4:0] exp_g;
      exp_g = 5'b10011;
      applyStimulus(1, 32'h4, 0, 0, 10'd0, 32'h0);
      waitSample();
      checkOutput("lim_gnt", 32'(gnt[1]), 32'(exp_g[i]));
      checkOutput("lim_rvalid", 32'(rvalid[1]), (i == 3 || i == 4) ? 32'd1 : 32'd0);
      checkOutput("lim_rdata", rdata[1], (i == 3 || i == 4) ? 32'h22222222 : 32'd0);
      if (i > 0) checkOutput("lim_busy", 32'(busy[1]), 32'd1);
    end
    for (int i = 0; i < 8; i++) applyStimulus(0, 32'h0, 0, 0, 10'd0, 32'h0);

    // Error responses: outside the window, then misaligned.
    applyStimulus(1, 32'h0000_1000, 0, 0, 10'd0, 32'h0);
    applyStimulus(1, 32'h0000_0002, 0, 0, 10'd0, 32'h0);
    waitSample();
    checkOutput("err1_rvalid", 32'(rvalid[0]), 32'd1);
    checkOutput("err1_err", 32'(err[0]), 32'd1);
    checkOutput("err1_rdata", rdata[0], 32'd0);
    applyStimulus(0, 32'h0, 0, 0, 10'd0, 32'h0);
    waitSample();
    checkOutput("err2_rvalid", 32'(rvalid[0]), 32'd1);
    checkOutput("err2_err", 32'(err[0]), 32'd1);
    checkOutput("err2_rdata", rdata[0], 32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 32'h0, 0, 0, 10'd0, 32'h0);

    // Stall, then preload word 5 and read it back.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h0, 1, 0, 10'd0, 32'h0);
      waitSample();
      checkOutput("stall_gnt", 32'(gnt), 32'd0);
    end
    applyStimulus(1, 32'h14, 0, 1, 10'd5, 32'hDEADBEEF);
    waitSample();
    checkOutput("load_gnt", 32'(gnt[0]), 32'd0);
    applyStimulus(1, 32'h14, 0, 0, 10'd0, 32'h0);
    waitSample();
    checkOutput("load_rd_gnt", 32'(gnt[0]), 32'd1);
    applyStimulus(0, 32'h0, 0, 0, 10'd0, 32'h0);
    waitSample();
    checkOutput("load_rd_rvalid", 32'(rvalid[0]), 32'd1);
    checkOutput("load_rd_rdata", rdata[0], 32'hDEADBEEF);
    for (int i = 0; i < 6; i++) applyStimulus(0, 32'h0, 0, 0, 10'd0, 32'h0);

    // Reset pulse one cycle after a grant on the latency-2 instance.
    applyStimulus(1, 32'h8, 0, 0, 10'd0, 32'h0);
    waitSample();
    checkOutput("rstmid_gnt", 32'(gnt[2]), 32'd1);
    applyStimulus(0, 32'h0, 0, 0, 10'd0, 32'h0);
    rst_n = 1'b0;
    applyStimulus(0, 32'h0, 0, 0, 10'd0, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waitSample();
      checkOutput("rstmid_rvalid", 32'(rvalid[2]), 32'd0);
      checkOutput("rstmid_busy", 32'(busy[2]), 32'd0);
      applyStimulus(0, 32'h0, 0, 0, 10'd0, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
